// File: rtl/spart_pkg.sv
// Shared definitions for the SPART link: receiver states, key bit positions,
// accepted ASCII codes and the default oversample divisor.
package spart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int unsigned KEY_UP    = 4;
    localparam int unsigned KEY_LEFT  = 3;
    localparam int unsigned KEY_DOWN  = 2;
    localparam int unsigned KEY_RIGHT = 1;
    localparam int unsigned KEY_SEL   = 0;

    localparam logic [7:0] ASCII_W_UC = 8'h57;
    localparam logic [7:0] ASCII_W_LC = 8'h77;
    localparam logic [7:0] ASCII_A_UC = 8'h41;
    localparam logic [7:0] ASCII_A_LC = 8'h61;
    localparam logic [7:0] ASCII_S_UC = 8'h53;
    localparam logic [7:0] ASCII_S_LC = 8'h73;
    localparam logic [7:0] ASCII_D_UC = 8'h44;
    localparam logic [7:0] ASCII_D_LC = 8'h64;
    localparam logic [7:0] ASCII_J_UC = 8'h4A;
    localparam logic [7:0] ASCII_J_LC = 8'h6A;

    localparam int unsigned DEFAULT_DIVISOR = 27;
    localparam int unsigned OVERSAMPLE      = 16;

    // One-hot key code for a received character; all zeros when not a key.
    function automatic logic [4:0] key_decode(input logic [7:0] c);
        logic [4:0] k;
        k = '0;
        case (c)
            ASCII_W_UC, ASCII_W_LC: k[KEY_UP]    = 1'b1;
            ASCII_A_UC, ASCII_A_LC: k[KEY_LEFT]  = 1'b1;
            ASCII_S_UC, ASCII_S_LC: k[KEY_DOWN]  = 1'b1;
            ASCII_D_UC, ASCII_D_LC: k[KEY_RIGHT] = 1'b1;
            ASCII_J_UC, ASCII_J_LC: k[KEY_SEL]   = 1'b1;
            default:                k = '0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/spart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIVISOR clocks, with a
// synchronous restart so the sample phase can be aligned to a start edge.
module spart_baud_tick
    import spart_pkg::*;
#(
    parameter int unsigned DIVISOR = DEFAULT_DIVISOR
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/spart_key_rx.sv
// SPART receive side: 8N1 deserialiser feeding the CPU key register with a
// one-hot W/A/S/D/J code and a single-cycle write strobe.
module spart_key_rx
    import spart_pkg::*;
#(
    parameter int unsigned DIVISOR = DEFAULT_DIVISOR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       SPART_we,
    output logic [4:0] SPART_keys,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

    rx_state_t  state, state_next;
    logic       sync1, rxs, rxs_d;
    logic       tick, restart, fall;
    logic       mid_tick, full_tick, good_stop, bad_stop;
    logic [3:0] sample_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic [4:0] key_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
            rxs_d <= rxs;
        end
    end

    assign fall     = rxs_d && !rxs;
    assign key_code = key_decode(shreg);

    spart_baud_tick #(.DIVISOR(DIVISOR)) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (fall)      state_next = START;
            START:     if (mid_tick)  state_next = rxs ? IDLE : DATA;
            DATA:      if (full_tick && bit_idx == 3'd7) state_next = STOP;
            STOP:      if (full_tick) state_next = rxs ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (full_tick && rxs) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        restart   = (state == IDLE) && fall;
        rx_busy   = (state != IDLE);
        mid_tick  = tick && (sample_cnt == MID_TICK);
        full_tick = tick && (sample_cnt == LAST_TICK);
        good_stop = (state == STOP) && full_tick && rxs;
        bad_stop  = (state == STOP) && full_tick && !rxs;
    end

    // sample_cnt wraps 15->0 on its own, so DATA->STOP->WAIT_IDLE need no explicit clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sample_cnt <= '0;
                    bit_idx    <= '0;
                end
                START: begin
                    if (mid_tick)  sample_cnt <= '0;
                    else if (tick) sample_cnt <= sample_cnt + 4'd1;
                    bit_idx <= '0;
                end
                DATA: begin
                    if (tick) sample_cnt <= sample_cnt + 4'd1;
                    if (full_tick) begin
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    if (tick) sample_cnt <= sample_cnt + 4'd1;
                end
                WAIT_IDLE: begin
                    if (!rxs)      sample_cnt <= '0;
                    else if (tick) sample_cnt <= sample_cnt + 4'd1;
                end
                default: sample_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            SPART_we   <= 1'b0;
            SPART_keys <= '0;
        end else begin
            rx_valid  <= good_stop;
            frame_err <= bad_stop;
            SPART_we  <= good_stop && (|key_code);
            if (good_stop) rx_data <= shreg;
            if (good_stop && (|key_code)) SPART_keys <= key_code;
        end
    end

endmodule

// File: doc/spart_key_rx.md
Name: spart_key_rx

Overview:
- Receive side of the SPART link, directly upstream of the CPU's key inputs.
- Deserialises 8N1 UART characters from the host terminal.
- Decodes W/A/S/D/J, in either case, into the 5-bit one-hot key vector.
- Issues a single-cycle write strobe that the CPU's decode/execute stage samples into its key register.

Parameters:
- DIVISOR, 27, clock cycles per 1/16-bit oversample tick (50 MHz, 115200 baud); legal range 2..4095
- OVERSAMPLE, 16, ticks per bit; fixed, not to be overridden

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rxd  input  1  serial line from host; idle high; asynchronous to clk
- SPART_we  output  1  one-cycle strobe: a recognised key was received
- SPART_keys  output  5  one-hot key: [4] W/w up, [3] A/a left, [2] S/s down, [1] D/d right, [0] J/j select
- rx_data  output  8  last correctly framed character, any value
- rx_valid  output  1  one-cycle strobe: rx_data updated
- frame_err  output  1  one-cycle strobe: stop bit sampled low
- rx_busy  output  1  high while in any state other than IDLE

Behaviour:
- Interface (already decided): single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: SPART_we=0, SPART_keys=5'b00000, rx_data=8'h00, rx_valid=0, frame_err=0, rx_busy=0, FSM=IDLE, tick and bit counters cleared.
- rxd passes through a two-flop synchroniser preset to 1; all logic below uses the synchronised value rxs.
- Tick generator: counts 0..DIVISOR-1 and asserts tick for one clk when the count wraps. It is restarted to 0 on the start edge so sample phase is frame-aligned.
- FSM states and transitions:
  - IDLE: rxs falling edge -> START; tick count and sample count cleared.
  - START: on the 8th tick (mid-bit), rxs=1 is a glitch -> IDLE with no strobes; rxs=0 -> DATA with bit index=0.
  - DATA: every 16th tick, sample rxs into shift register LSB first. After bit 7 -> STOP.
  - STOP: on the 16th tick, sample rxs.
    - rxs=1: go to IDLE and run the output update below.
    - rxs=0: pulse frame_err, go to WAIT_IDLE; no data or key update.
  - WAIT_IDLE: remain until rxs=1 for 16 consecutive ticks, then -> IDLE. A break condition never produces a character.
- Output update, registered in the cycle after the good stop sample:
  - rx_data <= shifted byte; rx_valid=1 for that one cycle.
  - If the byte is 0x57/0x77, 0x41/0x61, 0x53/0x73, 0x44/0x64 or 0x4A/0x6A: SPART_keys <= the matching one-hot code and SPART_we=1 in the same cycle as rx_valid.
  - Any other byte: SPART_we stays 0 and SPART_keys holds its previous value.
- SPART_keys is held until the next recognised key; it never returns to zero except on reset.
- Latency: the SPART_we edge occurs 1 clk after the stop-bit mid-sample, plus 2 clk of synchroniser delay relative to the line.
- Back-to-back characters: the start edge is detected in IDLE in the cycle after the stop sample, so characters with zero idle time between them are received without loss.
- No flow control: the strobes are never stalled or stretched, and the CPU must take them in the strobe cycle.
- rst_n asserted mid-frame: everything returns to reset values immediately. After release, a partially received frame resumes as IDLE waiting for a falling edge; later data bits that are 0 may cause a false start, and such frames are allowed to end in frame_err.
- rx_valid, SPART_we and frame_err are mutually exclusive with respect to frame_err: at most one frame result per stop bit.

Decomposition:
- Package spart_pkg:
  - FSM state encoding: IDLE, START, DATA, STOP, WAIT_IDLE.
  - Key bit indices: KEY_UP=4, KEY_LEFT=3, KEY_DOWN=2, KEY_RIGHT=1, KEY_SEL=0.
  - ASCII constants for the ten accepted characters.
  - Default DIVISOR.
- Sub-module spart_baud_tick: tick counter with synchronous restart input and tick output.
  - Reused later by the SPART transmit side.

Test Plan:
- Send 0x57 ('W') at DIVISOR=4 -> exactly one SPART_we pulse; SPART_keys=5'b10000; rx_data=0x57; rx_valid coincident with SPART_we.
- Send 0x6A ('j'), then immediately 0x64 ('d') with no idle gap -> two SPART_we pulses, 160 ticks apart; keys 5'b00001 then 5'b00010.
- Send 0x78 ('x') after 'W' -> rx_valid=1 with rx_data=0x78; SPART_we stays 0; SPART_keys remains 5'b10000.
- Drive rxd low for 4 ticks, then high -> no strobes of any kind; rx_busy returns low within 8 ticks.
- Send 0x41 with the stop bit forced low, then hold rxd low for 30 ticks, then send 0x53 -> one frame_err pulse; no SPART_we for the bad frame; the next frame yields SPART_keys=5'b00100.
- Assert rst_n for 3 clk at data bit 4 of 0x44 -> all outputs 0 immediately; the following clean 0x44 gives SPART_keys=5'b00010.
